// File: rtl/hilo_div_ctrl.sv
// HI/LO divide controller: accepts DIV/DIVU/MTHI/MTLO, sequences the iterative
// unsigned divider core, sign-corrects signed results and owns HI/LO.
module hilo_div_ctrl #(
    parameter int CORE_TIMEOUT = 40,
    parameter int TCNT_W       = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [31:0] op_rs,
    input  logic [31:0] op_rt,
    output logic        op_ready,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        core_fault,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        core_start,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    input  logic        core_end,
    input  logic [31:0] core_rem,
    input  logic [31:0] core_quo
);

    typedef enum logic [1:0] {IDLE, START, WAIT, FIX} state_t;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_MTHI = 2'd2;
    localparam logic [1:0] OP_MTLO = 2'd3;

    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(CORE_TIMEOUT - 1);
    localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);

    state_t            state, state_next;
    logic [TCNT_W-1:0] tcnt, tcnt_next;
    logic [31:0]       hi_next, lo_next, core_a_next, core_b_next;
    logic              neg_q, neg_r, neg_q_next, neg_r_next;
    logic              done_next, div_zero_next, core_fault_next;
    logic              signed_op;

    assign signed_op  = (op_code == OP_DIV);
    assign busy       = (state != IDLE);
    assign op_ready   = (state == IDLE) && !flush;
    assign core_start = (state == START) && !flush && !reset;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_next      = state;
        tcnt_next       = tcnt;
        hi_next         = hi;
        lo_next         = lo;
        core_a_next     = core_a;
        core_b_next     = core_b;
        neg_q_next      = neg_q;
        neg_r_next      = neg_r;
        done_next       = 1'b0;
        div_zero_next   = 1'b0;
        core_fault_next = 1'b0;

        if (flush) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            OP_MTHI: begin
                                hi_next   = op_rs;
                                done_next = 1'b1;
                            end
                            OP_MTLO: begin
                                lo_next   = op_rs;
                                done_next = 1'b1;
                            end
                            default: begin
                                if (op_rt == 32'd0) begin
                                    div_zero_next = 1'b1;
                                end else begin
                                    // Magnitudes for the core; 0x80000000 negates to itself,
                                    // which is the correct unsigned magnitude.
                                    core_a_next = (signed_op && op_rs[31]) ? -op_rs : op_rs;
                                    core_b_next = (signed_op && op_rt[31]) ? -op_rt : op_rt;
                                    neg_q_next  = signed_op && (op_rs[31] ^ op_rt[31]);
                                    neg_r_next  = signed_op && op_rs[31];
                                    state_next  = START;
                                end
                            end
                        endcase
                    end
                end
                START: begin
                    tcnt_next  = '0;
                    state_next = WAIT;
                end
                WAIT: begin
                    // tcnt==0 marks the first WAIT cycle, where core_end may still
                    // be the level left over from the previous operation.
                    if ((tcnt != '0) && core_end) begin
                        state_next = FIX;
                    end else if (tcnt == TCNT_LAST) begin
                        core_fault_next = 1'b1;
                        state_next      = IDLE;
                    end else begin
                        tcnt_next = tcnt + TCNT_ONE;
                    end
                end
                FIX: begin
                    lo_next    = neg_q ? -core_quo : core_quo;
                    hi_next    = neg_r ? -core_rem : core_rem;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            tcnt       <= '0;
            hi         <= '0;
            lo         <= '0;
            core_a     <= '0;
            core_b     <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            core_fault <= 1'b0;
        end else begin
            state      <= state_next;
            tcnt       <= tcnt_next;
            hi         <= hi_next;
            lo         <= lo_next;
            core_a     <= core_a_next;
            core_b     <= core_b_next;
            neg_q      <= neg_q_next;
            neg_r      <= neg_r_next;
            done       <= done_next;
            div_zero   <= div_zero_next;
            core_fault <= core_fault_next;
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl with a behavioural divider-core stub whose
// core_end level lingers one cycle past the next start, like a real core.
module tb_hilo_div_ctrl;

    logic        clock;
    logic        reset;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [31:0] op_rs;
    logic [31:0] op_rt;
    logic        op_ready;
    logic        flush;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        core_fault;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        core_start;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_end = 1'b0;
    logic [31:0] core_rem = 32'd0;
    logic [31:0] core_quo = 32'd0;

    localparam logic [1:0] DIV  = 2'd0;
    localparam logic [1:0] DIVU = 2'd1;
    localparam logic [1:0] MTHI = 2'd2;
    localparam logic [1:0] MTLO = 2'd3;

    int checks   = 0;
    int failures = 0;

    hilo_div_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .op_rs      (op_rs),
        .op_rt      (op_rt),
        .op_ready   (op_ready),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .core_fault (core_fault),
        .hi         (hi),
        .lo         (lo),
        .core_start (core_start),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_end   (core_end),
        .core_rem   (core_rem),
        .core_quo   (core_quo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Divider core stub: 32-cycle latency, results from the bench's own / and %.
    logic        core_hang = 1'b0;
    logic        clear_pend = 1'b0;
    int          core_cnt = 0;
    int          starts = 0;
    logic [31:0] q_pend = 32'd0;
    logic [31:0] r_pend = 32'd0;

    always @(posedge clock) begin
        clear_pend <= core_start;
        if (clear_pend) core_end <= 1'b0;
        if (core_start) begin
            starts   <= starts + 1;
            core_cnt <= 32;
            q_pend   <= core_a / core_b;
            r_pend   <= core_a % core_b;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1 && !core_hang) begin
                core_end <= 1'b1;
                core_quo <= q_pend;
                core_rem <= r_pend;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of cycle T+1.
    task automatic issue(input logic [1:0] code, input logic [31:0] rs, input logic [31:0] rt);
        op_valid = 1'b1;
        op_code  = code;
        op_rs    = rs;
        op_rt    = rt;
        @(negedge clock);
        op_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 80) begin
            @(negedge clock);
            n++;
        end
        check1({tag, "_done_seen"}, done, 1'b1);
    endtask

    initial begin
        int s0;
        int waits;
        int n;
        logic seen;

        reset    = 1'b1;
        flush    = 1'b0;
        op_valid = 1'b0;
        op_code  = 2'd0;
        op_rs    = 32'd0;
        op_rt    = 32'd0;
        repeat (2) @(negedge clock);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_div_zero", div_zero, 1'b0);
        check1("rst_core_fault", core_fault, 1'b0);
        check1("rst_core_start", core_start, 1'b0);
        check1("rst_op_ready", op_ready, 1'b1);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_core_a", core_a, 32'd0);
        check("rst_core_b", core_b, 32'd0);
        reset = 1'b0;

        // DIV 100/7
        s0 = starts;
        issue(DIV, 32'd100, 32'd7);
        check1("t1_core_start", core_start, 1'b1);
        check1("t1_busy", busy, 1'b1);
        check1("t1_op_ready", op_ready, 1'b0);
        check("t1_core_a", core_a, 32'd100);
        check("t1_core_b", core_b, 32'd7);
        @(negedge clock);
        check1("t1_start_one_cycle", core_start, 1'b0);
        wait_done("t1");
        check("t1_lo", lo, 32'd14);
        check("t1_hi", hi, 32'd2);
        check1("t1_busy_low", busy, 1'b0);
        check("t1_start_count", starts - s0, 32'd1);
        @(negedge clock);
        check1("t1_done_pulse", done, 1'b0);

        // Signed negative dividend, then the same operands unsigned
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        check("t2_core_a", core_a, 32'd7);
        check("t2_core_b", core_b, 32'd2);
        wait_done("t2s");
        check("t2s_lo", lo, 32'hFFFF_FFFD);
        check("t2s_hi", hi, 32'hFFFF_FFFF);
        @(negedge clock);
        issue(DIVU, 32'hFFFF_FFF9, 32'd2);
        check("t2u_core_a", core_a, 32'hFFFF_FFF9);
        wait_done("t2u");
        check("t2u_lo", lo, 32'h7FFF_FFFC);
        check("t2u_hi", hi, 32'd1);
        @(negedge clock);

        // Overflow case and unsigned max dividend
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check1("t3_no_div_zero", div_zero, 1'b0);
        check("t3_core_a", core_a, 32'h8000_0000);
        check("t3_core_b", core_b, 32'd1);
        wait_done("t3s");
        check("t3s_lo", lo, 32'h8000_0000);
        check("t3s_hi", hi, 32'd0);
        @(negedge clock);
        issue(DIVU, 32'hFFFF_FFFF, 32'd2);
        wait_done("t3u");
        check("t3u_lo", lo, 32'h7FFF_FFFF);
        check("t3u_hi", hi, 32'd1);
        @(negedge clock);

        // MTHI/MTLO then divide by zero
        issue(MTHI, 32'h11, 32'd0);
        check1("t4_mthi_done", done, 1'b1);
        check("t4_mthi_hi", hi, 32'h11);
        check1("t4_mthi_busy", busy, 1'b0);
        issue(MTLO, 32'h22, 32'd0);
        check1("t4_mtlo_done", done, 1'b1);
        check("t4_mtlo_lo", lo, 32'h22);
        s0 = starts;
        issue(DIVU, 32'd5, 32'd0);
        check1("t4_div_zero", div_zero, 1'b1);
        check1("t4_no_done", done, 1'b0);
        check1("t4_no_core_start", core_start, 1'b0);
        check1("t4_busy", busy, 1'b0);
        check1("t4_op_ready", op_ready, 1'b1);
        check("t4_hi", hi, 32'h11);
        check("t4_lo", lo, 32'h22);
        @(negedge clock);
        check1("t4_div_zero_pulse", div_zero, 1'b0);
        check("t4_start_count", starts - s0, 32'd0);

        // Flush in WAIT cycle 10
        issue(DIV, 32'd100, 32'd7);
        repeat (10) @(negedge clock);
        check1("t5_in_wait", busy, 1'b1);
        flush = 1'b1;
        #1;
        check1("t5_flush_op_ready", op_ready, 1'b0);
        @(negedge clock);
        flush = 1'b0;
        check1("t5_flush_idle", busy, 1'b0);
        check1("t5_flush_no_done", done, 1'b0);
        check("t5_flush_hi", hi, 32'h11);
        check("t5_flush_lo", lo, 32'h22);
        // Flush with a request pending in IDLE blocks acceptance
        flush    = 1'b1;
        op_valid = 1'b1;
        op_code  = MTHI;
        op_rs    = 32'h99;
        #1;
        check1("t5_idle_flush_op_ready", op_ready, 1'b0);
        @(negedge clock);
        flush    = 1'b0;
        op_valid = 1'b0;
        check("t5_idle_flush_hi", hi, 32'h11);
        check1("t5_idle_flush_no_done", done, 1'b0);
        // Let the aborted op's core finish so core_end is left high
        seen = 1'b0;
        repeat (25) begin
            @(negedge clock);
            seen = seen | done | div_zero | core_fault;
        end
        check1("t5_no_late_pulse", seen, 1'b0);
        check1("t5_stale_core_end", core_end, 1'b1);
        issue(MTLO, 32'hABCD, 32'd0);
        check1("t5_mtlo_done", done, 1'b1);
        check("t5_mtlo_lo", lo, 32'hABCD);
        issue(DIVU, 32'd50, 32'd5);
        wait_done("t5_stale");
        check("t5_stale_lo", lo, 32'd10);
        check("t5_stale_hi", hi, 32'd0);
        @(negedge clock);

        // Core never answers: timeout after 40 WAIT cycles
        core_hang = 1'b1;
        issue(DIVU, 32'd9, 32'd3);
        check1("t6_core_start", core_start, 1'b1);
        waits = 0;
        n     = 0;
        while (!core_fault && n < 100) begin
            @(negedge clock);
            n++;
            if (busy) waits++;
        end
        check1("t6_core_fault", core_fault, 1'b1);
        check("t6_wait_cycles", waits, 32'd40);
        check1("t6_idle", busy, 1'b0);
        check1("t6_no_done", done, 1'b0);
        check("t6_hi", hi, 32'd0);
        check("t6_lo", lo, 32'd10);
        @(negedge clock);
        check1("t6_fault_pulse", core_fault, 1'b0);
        core_hang = 1'b0;

        // Reset in the middle of WAIT
        issue(DIV, 32'd100, 32'd7);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check1("t7_busy", busy, 1'b0);
        check1("t7_core_start", core_start, 1'b0);
        check1("t7_done", done, 1'b0);
        check1("t7_core_fault", core_fault, 1'b0);
        check("t7_hi", hi, 32'd0);
        check("t7_lo", lo, 32'd0);
        check("t7_core_a", core_a, 32'd0);
        check("t7_core_b", core_b, 32'd0);
        reset = 1'b0;
        issue(DIVU, 32'd9, 32'd3);
        wait_done("t7_after");
        check("t7_after_lo", lo, 32'd3);
        check("t7_after_hi", hi, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
Controller between the CPU control unit and the 32-cycle iterative unsigned divider core.
- Accepts DIV, DIVU, MTHI and MTLO operations through a valid/ready handshake.
- For signed DIV, takes operand magnitudes, sequences the core's start/end protocol and sign-corrects the results.
- Owns the architectural HI/LO registers, flags divide-by-zero and supports pipeline flush.

Parameters:
CORE_TIMEOUT, 40, max cycles waited for core_end after core_start before declaring a core fault.
TCNT_W, 6, width of the timeout counter; must hold CORE_TIMEOUT.

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
op_valid  in  1  operation request
op_code  in  2  0=DIV (signed), 1=DIVU, 2=MTHI, 3=MTLO
op_rs  in  32  dividend / MTHI-MTLO source
op_rt  in  32  divisor
op_ready  out  1  controller can accept (IDLE and !flush)
flush  in  1  abort any in-flight operation
busy  out  1  high whenever state != IDLE; CPU stalls on MFHI/MFLO/new muldiv
done  out  1  one-cycle pulse when HI/LO are written
div_zero  out  1  one-cycle pulse: divisor was zero
core_fault  out  1  one-cycle pulse: timeout expired
hi  out  32  architectural HI
lo  out  32  architectural LO
core_start  out  1  one-cycle start pulse to divider core
core_a  out  32  unsigned dividend to core, held stable START..WAIT
core_b  out  32  unsigned divisor to core, held stable START..WAIT
core_end  in  1  core completion level; stays high until next start
core_rem  in  32  core remainder (valid with core_end)
core_quo  in  32  core quotient (valid with core_end)

Behaviour:
- Reset values: state=IDLE, hi=0, lo=0, core_a=0, core_b=0, timeout counter=0; core_start, done, div_zero, core_fault, busy all 0.
- States: IDLE, START, WAIT, FIX.
- Accept: op_valid && op_ready at edge T.
  - MTHI/MTLO: hi (resp. lo) <= op_rs at T; done=1 during cycle T+1; stays IDLE.
  - DIV/DIVU, op_rt==0: no core activity; div_zero=1 during T+1; hi/lo unchanged; stays IDLE.
  - DIV/DIVU, op_rt!=0: latch core_a/core_b, neg_q, neg_r; go to START.
- Operand latching:
  - DIVU: core_a=op_rs, core_b=op_rt.
  - DIV: core_a=|op_rs|, core_b=|op_rt| (two's-complement negate if bit31; 0x80000000 stays 0x80000000 as unsigned).
  - neg_q = signs differ (DIV only); neg_r = op_rs[31] (DIV only).
- START (1 cycle): core_start=1; clear timeout counter; go to WAIT.
- WAIT:
  - First WAIT cycle ignores core_end (guards stale level from the previous op).
  - Afterwards, core_end=1 goes to FIX.
  - Counter increments each WAIT cycle. Reaching CORE_TIMEOUT: core_fault pulse, hi/lo unchanged, go to IDLE.
- FIX (1 cycle):
  - lo <= neg_q ? -core_quo : core_quo.
  - hi <= neg_r ? -core_rem : core_rem.
  - done=1 during the cycle after the FIX edge; go to IDLE.
- DIV latency: accept at T, core_start in cycle T+1, hi/lo written at end of FIX, which occurs once core_end has been seen (about 34 cycles). busy covers START..FIX.
- Overflow: 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0; no exception.
- Flush:
  - In any state, the next state is IDLE, hi/lo unchanged, and no done, div_zero or core_fault is pulsed.
  - Flush in START suppresses core_start.
  - Flush with op_valid in IDLE: op not accepted (op_ready=0).
- op_valid while busy is ignored; requester holds it until op_ready.
- Reset mid-operation returns to reset values immediately; core_start is not asserted.
- done, div_zero and core_fault are mutually exclusive per operation.

Test Plan:
1. DIV rs=100, rt=7 -> core_a=100, core_b=7, single core_start pulse; after core_end: lo=14, hi=2, done one cycle, busy low next cycle.
2. DIV rs=0xFFFFFFF9 (-7), rt=2 -> core_a=7; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU same operands -> lo=0x7FFFFFFC, hi=1.
3. DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0, no div_zero. DIVU rs=0xFFFFFFFF, rt=2 -> lo=0x7FFFFFFF, hi=1.
4. DIVU rs=5, rt=0 with hi=0x11, lo=0x22 preset via MTHI/MTLO -> div_zero pulse at T+1, no core_start, hi=0x11, lo=0x22, op_ready stays high.
5. Start DIV 100/7, assert flush in WAIT cycle 10 -> IDLE next cycle, no done, hi/lo unchanged. Immediately issue MTLO 0xABCD -> lo=0xABCD, done pulse. Next DIV ignores the stale core_end in its first WAIT cycle.
6. Hold core_end low after start -> core_fault pulse after exactly 40 WAIT cycles, state IDLE; assert reset during WAIT in a separate run -> all outputs at reset values next cycle.
